// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end for a shared combinational ALU.
// One operation in flight: grant in IDLE, one EXEC cycle, hold result in RESP.
module alu_arbiter #(
   parameter int DATA_WIDTH    = 32,
   parameter int OPCODE_LENGTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     req0_valid,
   input  logic                     req1_valid,
   output logic                     req0_ready,
   output logic                     req1_ready,
   input  logic [DATA_WIDTH-1:0]    req0_srca,
   input  logic [DATA_WIDTH-1:0]    req0_srcb,
   input  logic [DATA_WIDTH-1:0]    req1_srca,
   input  logic [DATA_WIDTH-1:0]    req1_srcb,
   input  logic [OPCODE_LENGTH-1:0] req0_op,
   input  logic [OPCODE_LENGTH-1:0] req1_op,
   output logic [DATA_WIDTH-1:0]    alu_srca,
   output logic [DATA_WIDTH-1:0]    alu_srcb,
   output logic [OPCODE_LENGTH-1:0] alu_op,
   input  logic [DATA_WIDTH-1:0]    alu_result,
   output logic                     rsp_valid,
   output logic                     rsp_id,
   output logic [DATA_WIDTH-1:0]    rsp_result,
   input  logic                     rsp_ready,
   output logic [15:0]              op_count
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t                   state;
   logic                     last_grant;
   logic                     gnt0, gnt1;
   logic                     id_q, vld_q;
   logic [DATA_WIDTH-1:0]    srca_q, srcb_q, res_q;
   logic [OPCODE_LENGTH-1:0] op_q;
   logic [15:0]              cnt_q;

   // On a tie the requester that did not win last time is granted.
   always_comb begin
      gnt0 = req0_valid & (~req1_valid | last_grant);
      gnt1 = req1_valid & (~req0_valid | ~last_grant);
   end

   assign req0_ready = (state == IDLE) & gnt0;
   assign req1_ready = (state == IDLE) & gnt1;
   assign alu_srca   = srca_q;
   assign alu_srcb   = srcb_q;
   assign alu_op     = op_q;
   assign rsp_valid  = vld_q;
   assign rsp_id     = id_q;
   assign rsp_result = res_q;
   assign op_count   = cnt_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         id_q       <= 1'b0;
         vld_q      <= 1'b0;
         srca_q     <= '0;
         srcb_q     <= '0;
         op_q       <= '0;
         res_q      <= '0;
         cnt_q      <= '0;
      end else begin
         case (state)
            IDLE: if (gnt0 | gnt1) begin
               srca_q     <= gnt1 ? req1_srca : req0_srca;
               srcb_q     <= gnt1 ? req1_srcb : req0_srcb;
               op_q       <= gnt1 ? req1_op   : req0_op;
               id_q       <= gnt1;
               last_grant <= gnt1;
               state      <= EXEC;
            end
            EXEC: begin
               res_q <= alu_result;
               vld_q <= 1'b1;
               state <= RESP;
            end
            RESP: if (rsp_ready) begin
               vld_q <= 1'b0;
               cnt_q <= cnt_q + 16'd1;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized bench for alu_arbiter; the bench plays the ALU and keeps its own
// round-robin/transaction model to predict grants, results and counts.
module tb_alu_arbiter;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        req0_valid = 0, req1_valid = 0;
   logic        req0_ready, req1_ready;
   logic [31:0] req0_srca = 0, req0_srcb = 0, req1_srca = 0, req1_srcb = 0;
   logic [3:0]  req0_op = 0, req1_op = 0;
   logic [31:0] alu_srca, alu_srcb, alu_result, rsp_result;
   logic [3:0]  alu_op;
   logic        rsp_valid, rsp_id;
   logic        rsp_ready = 0;
   logic [15:0] op_count;

   int vectors = 0;
   int miscompares = 0;
   int exp_last = 1;
   int exp_count = 0;

   alu_arbiter #(.DATA_WIDTH(32), .OPCODE_LENGTH(4)) dut (
      .clk(clk), .reset(reset),
      .req0_valid(req0_valid), .req1_valid(req1_valid),
      .req0_ready(req0_ready), .req1_ready(req1_ready),
      .req0_srca(req0_srca), .req0_srcb(req0_srcb),
      .req1_srca(req1_srca), .req1_srcb(req1_srcb),
      .req0_op(req0_op), .req1_op(req1_op),
      .alu_srca(alu_srca), .alu_srcb(alu_srcb), .alu_op(alu_op),
      .alu_result(alu_result),
      .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_result(rsp_result),
      .rsp_ready(rsp_ready), .op_count(op_count)
   );

   always #5 clk = ~clk;

   // Reference ALU: a few real ops, unused codes map to an op-dependent mix.
   function automatic logic [31:0] alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         4'b0000: alu_fn = a & b;
         4'b0001: alu_fn = a | b;
         4'b0010: alu_fn = a + b;
         4'b0110: alu_fn = a ^ b;
         4'b1111: alu_fn = a - b;
         default: alu_fn = a ^ {b[15:0], b[31:16]} ^ {28'h0, op};
      endcase
   endfunction

   always_comb alu_result = alu_fn(alu_op, alu_srca, alu_srcb);

   task automatic do_reset();
      @(negedge clk);
      req0_valid = 0; req1_valid = 0; rsp_ready = 0;
      reset = 1;
      @(negedge clk);
      reset = 0;
      exp_last = 1; exp_count = 0;
   endtask

   task automatic test_reset();
      #2;
      vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
      vectors++; if (rsp_id !== 1'b0) begin miscompares++; $display("FAIL reset_rsp_id got %b want 0", rsp_id); end
      vectors++; if (rsp_result !== 32'h0) begin miscompares++; $display("FAIL reset_rsp_result got %h want 0", rsp_result); end
      vectors++; if (op_count !== 16'h0) begin miscompares++; $display("FAIL reset_op_count got %h want 0", op_count); end
      vectors++; if ({alu_srca, alu_srcb, alu_op} !== 68'h0) begin miscompares++; $display("FAIL reset_operands got %h/%h/%h want 0", alu_srca, alu_srcb, alu_op); end
      @(negedge clk);
      reset = 0;
   endtask

   task automatic test_single();
      req0_valid = 1; req0_srca = 5; req0_srcb = 7; req0_op = 4'b0010;
      #1;
      vectors++; if ({req0_ready, req1_ready} !== 2'b10) begin miscompares++; $display("FAIL single_ready got %b want 10", {req0_ready, req1_ready}); end
      @(negedge clk); req0_valid = 0; #1;
      vectors++; if ({alu_srca, alu_srcb, alu_op} !== {32'd5, 32'd7, 4'b0010}) begin miscompares++; $display("FAIL single_alu_in got %0d/%0d/%b want 5/7/0010", alu_srca, alu_srcb, alu_op); end
      vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL single_exec_valid got %b want 0", rsp_valid); end
      @(negedge clk); #1;
      vectors++; if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, 1'b0, 32'd12}) begin miscompares++; $display("FAIL single_rsp got v%b id%b %0d want v1 id0 12", rsp_valid, rsp_id, rsp_result); end
      vectors++; if (op_count !== 16'd0) begin miscompares++; $display("FAIL single_count_pre got %0d want 0", op_count); end
      rsp_ready = 1;
      @(negedge clk); rsp_ready = 0; #1;
      vectors++; if ({rsp_valid, op_count} !== {1'b0, 16'd1}) begin miscompares++; $display("FAIL single_done got v%b cnt%0d want v0 cnt1", rsp_valid, op_count); end
      exp_last = 0; exp_count = 1;
   endtask

   task automatic test_tie();
      int n0 = 0, n1 = 0, nr = 0;
      bit clr0 = 0, clr1 = 0;
      logic        ids[4];
      logic [31:0] res[4];
      do_reset();
      req0_srca = 10; req0_srcb = 3; req0_op = 4'b1111;
      req1_srca = 32'hF0; req1_srcb = 32'h0F; req1_op = 4'b0110;
      req0_valid = 1; req1_valid = 1; rsp_ready = 1;
      for (int c = 0; c < 10; c++) begin
         if (c > 0) @(negedge clk);
         if (clr0) req0_valid = 0;
         if (clr1) req1_valid = 0;
         #1;
         if (req0_ready) begin n0++; clr0 = 1; end
         if (req1_ready) begin n1++; clr1 = 1; end
         if (rsp_valid && nr < 4) begin ids[nr] = rsp_id; res[nr] = rsp_result; nr++; end
      end
      rsp_ready = 0;
      vectors++; if (n0 != 1 || n1 != 1) begin miscompares++; $display("FAIL tie_ready_counts got %0d/%0d want 1/1", n0, n1); end
      vectors++; if (nr != 2) begin miscompares++; $display("FAIL tie_rsp_count got %0d want 2", nr); end
      else begin
         vectors++; if ({ids[0], res[0]} !== {1'b0, 32'd7}) begin miscompares++; $display("FAIL tie_first got id%b %h want id0 7", ids[0], res[0]); end
         vectors++; if ({ids[1], res[1]} !== {1'b1, 32'hFF}) begin miscompares++; $display("FAIL tie_second got id%b %h want id1 ff", ids[1], res[1]); end
      end
      vectors++; if (op_count !== 16'd2) begin miscompares++; $display("FAIL tie_count got %0d want 2", op_count); end
      exp_last = 1; exp_count = 2;
   endtask

   task automatic test_backpressure();
      logic [31:0] r;
      logic [15:0] c0;
      @(negedge clk);
      req1_valid = 1; req1_srca = $urandom; req1_srcb = $urandom; req1_op = 4'b0010;
      r = req1_srca + req1_srcb;
      @(negedge clk); req1_valid = 0;
      @(negedge clk); req0_valid = 1; c0 = op_count;
      for (int i = 0; i < 5; i++) begin
         #1;
         vectors++; if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, 1'b1, r}) begin miscompares++; $display("FAIL bp_hold%0d got v%b id%b %h want v1 id1 %h", i, rsp_valid, rsp_id, rsp_result, r); end
         vectors++; if ({req0_ready, req1_ready} !== 2'b00 || op_count !== 16'(exp_count)) begin miscompares++; $display("FAIL bp_idle%0d got rdy%b%b cnt%0d want 00 cnt%0d", i, req0_ready, req1_ready, op_count, exp_count); end
         @(negedge clk);
      end
      req0_valid = 0; rsp_ready = 1;
      @(negedge clk); rsp_ready = 0; #1;
      exp_count++; exp_last = 1;
      vectors++; if ({rsp_valid, op_count} !== {1'b0, 16'(exp_count)} || c0 !== 16'(exp_count - 1)) begin miscompares++; $display("FAIL bp_accept got v%b cnt%0d want v0 cnt%0d", rsp_valid, op_count, exp_count); end
   endtask

   task automatic test_fairness();
      int ng = 0, nr = 0, g;
      int q[$];
      do_reset();
      req0_srca = $urandom; req0_srcb = $urandom; req0_op = 4'b0010;
      req1_srca = $urandom; req1_srcb = $urandom; req1_op = 4'b1111;
      req0_valid = 1; req1_valid = 1; rsp_ready = 1;
      for (int c = 0; c < 60 && nr < 8; c++) begin
         if (c > 0) @(negedge clk);
         if (ng == 8) begin req0_valid = 0; req1_valid = 0; end
         #1;
         if (req0_ready || req1_ready) begin
            g = 1 - exp_last;
            vectors++; if (ng >= 8 || {req0_ready, req1_ready} !== ((g == 0) ? 2'b10 : 2'b01)) begin miscompares++; $display("FAIL fair_grant%0d got %b%b want grant %0d", ng, req0_ready, req1_ready, g); end
            q.push_back(g); exp_last = g; ng++;
         end
         if (rsp_valid && q.size() > 0) begin
            g = q.pop_front();
            vectors++; if (rsp_id !== g[0] || rsp_result !== ((g == 0) ? req0_srca + req0_srcb : req1_srca - req1_srcb)) begin miscompares++; $display("FAIL fair_rsp%0d got id%b %h want id%0d", nr, rsp_id, rsp_result, g); end
            nr++;
         end
      end
      vectors++; if (nr != 8) begin miscompares++; $display("FAIL fair_timeout got %0d responses want 8", nr); end
      @(negedge clk); rsp_ready = 0; req0_valid = 0; req1_valid = 0; #1;
      vectors++; if (op_count !== 16'd8) begin miscompares++; $display("FAIL fair_count got %0d want 8", op_count); end
      exp_count = 8;
   endtask

   task automatic test_random();
      logic [31:0] a[2], b[2], r;
      logic [3:0]  op[2];
      bit v0, v1;
      int g, stall;
      for (int t = 0; t < 40; t++) begin
         @(negedge clk);
         for (int k = 0; k < 2; k++) begin a[k] = $urandom; b[k] = $urandom; op[k] = 4'($urandom_range(0, 15)); end
         do begin v0 = 1'($urandom); v1 = 1'($urandom); end while (!v0 && !v1);
         req0_srca = a[0]; req0_srcb = b[0]; req0_op = op[0];
         req1_srca = a[1]; req1_srcb = b[1]; req1_op = op[1];
         req0_valid = v0; req1_valid = v1;
         g = (v0 && v1) ? 1 - exp_last : (v0 ? 0 : 1);
         r = alu_fn(op[g], a[g], b[g]);
         #1;
         vectors++; if ({req0_ready, req1_ready} !== ((g == 0) ? 2'b10 : 2'b01)) begin miscompares++; $display("FAIL rnd_grant%0d got %b%b want grant %0d (v=%b%b)", t, req0_ready, req1_ready, g, v0, v1); end
         @(negedge clk); #1;
         vectors++; if ({req0_ready, req1_ready} !== 2'b00 || alu_op !== op[g] || alu_srca !== a[g]) begin miscompares++; $display("FAIL rnd_exec%0d got rdy%b%b op%b a%h want 00 op%b a%h", t, req0_ready, req1_ready, alu_op, alu_srca, op[g], a[g]); end
         stall = $urandom_range(0, 3);
         for (int s = 0; s <= stall; s++) begin
            @(negedge clk); #1;
            vectors++; if ({rsp_valid, rsp_id, rsp_result} !== {1'b1, g[0], r}) begin miscompares++; $display("FAIL rnd_rsp%0d got v%b id%b %h want v1 id%0d %h", t, rsp_valid, rsp_id, rsp_result, g, r); end
         end
         rsp_ready = 1; req0_valid = 0; req1_valid = 0;
         @(negedge clk); rsp_ready = 0; #1;
         exp_count++; exp_last = g;
         vectors++; if ({rsp_valid, op_count} !== {1'b0, 16'(exp_count)}) begin miscompares++; $display("FAIL rnd_count%0d got v%b cnt%0d want v0 cnt%0d", t, rsp_valid, op_count, exp_count); end
      end
   endtask

   task automatic test_midreset();
      @(negedge clk);
      req1_valid = 1; req1_srca = 32'h1234; req1_srcb = 32'h1; req1_op = 4'b0010;
      @(negedge clk); req1_valid = 0;
      @(negedge clk); #1;
      vectors++; if (rsp_valid !== 1'b1) begin miscompares++; $display("FAIL mid_resp got v%b want 1", rsp_valid); end
      #1 reset = 1; #1;
      vectors++; if ({rsp_valid, op_count, rsp_result, alu_srca} !== 81'h0) begin miscompares++; $display("FAIL mid_abort got v%b cnt%0d res%h a%h want all 0", rsp_valid, op_count, rsp_result, alu_srca); end
      @(negedge clk); reset = 0;
      req0_srca = 9; req0_srcb = 4; req0_op = 4'b1101;
      req1_srca = 1; req1_srcb = 2; req1_op = 4'b1110;
      req0_valid = 1; req1_valid = 1; rsp_ready = 1; #1;
      vectors++; if ({req0_ready, req1_ready} !== 2'b10) begin miscompares++; $display("FAIL mid_tie got %b%b want 10", req0_ready, req1_ready); end
      @(negedge clk); req0_valid = 0; req1_valid = 0;
      @(negedge clk); #1;
      vectors++; if ({rsp_id, rsp_result} !== {1'b0, alu_fn(4'b1101, 32'd9, 32'd4)}) begin miscompares++; $display("FAIL mid_unused_op got id%b %h", rsp_id, rsp_result); end
      @(negedge clk); rsp_ready = 0; #1;
      vectors++; if (op_count !== 16'd1) begin miscompares++; $display("FAIL mid_count got %0d want 1", op_count); end
      exp_count = 1; exp_last = 0;
   endtask

   task automatic test_wrap();
      @(negedge clk);
      force dut.cnt_q = 16'hFFFF;
      #1 release dut.cnt_q;
      #1;
      vectors++; if (op_count !== 16'hFFFF) begin miscompares++; $display("FAIL wrap_preload got %h want ffff", op_count); end
      req0_valid = 1; req0_srca = 1; req0_srcb = 1; req0_op = 4'b0000; rsp_ready = 1;
      @(negedge clk); req0_valid = 0;
      @(negedge clk);
      @(negedge clk); rsp_ready = 0; #1;
      vectors++; if ({rsp_valid, op_count} !== {1'b0, 16'h0000}) begin miscompares++; $display("FAIL wrap_count got v%b %h want v0 0000", rsp_valid, op_count); end
   endtask

   initial begin
      test_reset();
      test_single();
      test_tie();
      test_backpressure();
      test_fairness();
      test_random();
      test_midreset();
      test_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: run did not complete within 200000 time units");
      $fatal(1, "watchdog");
   end

endmodule
